// File: rtl/collision_detect_pkg.sv
// Shared types and constants for the road-object collision detector.
package hp_pkg;

  localparam int NUM_OBJS = 8;
  localparam int COORD_W  = 11;

  typedef enum logic [2:0] {
    ROCK   = 3'd0,
    TREE   = 3'd1,
    BARREL = 3'd2,
    NOS    = 3'd3,
    LIFE   = 3'd4,
    CONE   = 3'd5,
    OIL    = 3'd6,
    SHIELD = 3'd7
  } obj_kind_e;

  // Rock, tree, barrel, cone and oil hurt the car
  localparam logic [NUM_OBJS-1:0] HAZARD_MASK = 8'b0110_0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } coll_state_e;

  function automatic logic [COORD_W:0] zext(input logic [COORD_W-1:0] v);
    return {1'b0, v};
  endfunction

endpackage

// File: rtl/collision_detect_if.sv
// Object-position bus between spawner/car-motion (master) and collision_detect (slave).
interface collision_detect_if;
  import hp_pkg::*;

  logic               frame_tick;
  logic [COORD_W-1:0] CarX, CarY, CarW, CarH;
  logic [COORD_W-1:0] ObjX [NUM_OBJS];
  logic [COORD_W-1:0] ObjY [NUM_OBJS];
  logic [COORD_W-1:0] ObjW [NUM_OBJS];
  logic [COORD_W-1:0] ObjH [NUM_OBJS];
  logic [NUM_OBJS-1:0] trshdObjs;
  logic               damage_pulse, nos_pulse, life_pulse;
  logic               shield_active, invuln, busy, overrun;

  modport master (
    output frame_tick, CarX, CarY, CarW, CarH, ObjX, ObjY, ObjW, ObjH,
    input  trshdObjs, damage_pulse, nos_pulse, life_pulse,
           shield_active, invuln, busy, overrun
  );

  modport slave (
    input  frame_tick, CarX, CarY, CarW, CarH, ObjX, ObjY, ObjW, ObjH,
    output trshdObjs, damage_pulse, nos_pulse, life_pulse,
           shield_active, invuln, busy, overrun
  );

endinterface

// File: rtl/collision_detect_box_overlap.sv
// Combinational overlap test of the car box against one margin-trimmed object box.
module box_overlap
  import hp_pkg::*;
#(
  parameter int MARGIN = 2
) (
  input  logic [COORD_W-1:0] i_car_x,
  input  logic [COORD_W-1:0] i_car_y,
  input  logic [COORD_W-1:0] i_car_w,
  input  logic [COORD_W-1:0] i_car_h,
  input  logic [COORD_W-1:0] i_obj_x,
  input  logic [COORD_W-1:0] i_obj_y,
  input  logic [COORD_W-1:0] i_obj_w,
  input  logic [COORD_W-1:0] i_obj_h,
  output logic               o_hit
);

  localparam logic [COORD_W:0] W_M  = (COORD_W+1)'(MARGIN);
  localparam logic [COORD_W:0] W_2M = (COORD_W+1)'(2 * MARGIN);

  logic             w_size_ok;
  logic [COORD_W:0] w_ox, w_oy, w_obj_r, w_obj_b, w_car_r, w_car_b;

  // 12-bit sums cannot wrap; right edge of the trimmed box is X+W-M
  assign w_size_ok = (zext(i_obj_w) > W_2M) && (zext(i_obj_h) > W_2M);
  assign w_ox      = zext(i_obj_x) + W_M;
  assign w_oy      = zext(i_obj_y) + W_M;
  assign w_obj_r   = zext(i_obj_x) + zext(i_obj_w) - W_M;
  assign w_obj_b   = zext(i_obj_y) + zext(i_obj_h) - W_M;
  assign w_car_r   = zext(i_car_x) + zext(i_car_w);
  assign w_car_b   = zext(i_car_y) + zext(i_car_h);

  assign o_hit = w_size_ok
               && (zext(i_car_x) < w_obj_r) && (w_ox < w_car_r)
               && (zext(i_car_y) < w_obj_b) && (w_oy < w_car_b);

endmodule

// File: rtl/collision_detect.sv
// Per-frame scan of 8 road objects against the car box; gameplay event pulses and timers.
// Optional macro COLLIDE_SHIELD_EN enables the shield pickup (object 7) and its timer.
module collision_detect
  import hp_pkg::*;
#(
  parameter int HIT_MARGIN    = 2,
  parameter int INVULN_FRAMES = 60,
  parameter int SHIELD_FRAMES = 300
) (
  input logic          i_clk,
  input logic          i_reset,
  collision_detect_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_SCAN = 2'(SCAN);
  localparam logic [1:0] ST_DONE = 2'(DONE);

  localparam int TMR_MAX = (INVULN_FRAMES > SHIELD_FRAMES) ? INVULN_FRAMES : SHIELD_FRAMES;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int IDX_NOS  = int'(NOS);
  localparam int IDX_LIFE = int'(LIFE);

  logic [1:0]          r_state;
  logic [2:0]          r_idx;
  logic [COORD_W-1:0]  r_car_x, r_car_y, r_car_w, r_car_h;
  logic [NUM_OBJS-1:0] r_hits, r_trshd;
  logic                r_dmg, r_nos, r_life, r_overrun;
  logic [TMR_W-1:0]    r_invuln_tmr;

  logic                w_hit, w_start, w_last, w_damage, w_shield_on;
  logic [NUM_OBJS-1:0] w_hits_next;

  box_overlap #(.MARGIN(HIT_MARGIN)) u_overlap (
    .i_car_x (r_car_x),
    .i_car_y (r_car_y),
    .i_car_w (r_car_w),
    .i_car_h (r_car_h),
    .i_obj_x (bus.ObjX[r_idx]),
    .i_obj_y (bus.ObjY[r_idx]),
    .i_obj_w (bus.ObjW[r_idx]),
    .i_obj_h (bus.ObjH[r_idx]),
    .o_hit   (w_hit)
  );

  assign w_start = bus.frame_tick && (r_state == ST_IDLE);
  assign w_last  = (r_state == ST_SCAN) && (r_idx == 3'd7);

  always_comb begin
    w_hits_next = r_hits;
    if (r_state == ST_SCAN) w_hits_next[r_idx] = w_hit;
  end

  // Evaluated against the timers as they stood before this frame's loads
  assign w_damage = w_last && (|(w_hits_next & HAZARD_MASK))
                 && (r_invuln_tmr == '0) && !w_shield_on;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= 3'd0;
      r_car_x   <= '0;
      r_car_y   <= '0;
      r_car_w   <= '0;
      r_car_h   <= '0;
      r_hits    <= '0;
      r_trshd   <= '0;
      r_dmg     <= 1'b0;
      r_nos     <= 1'b0;
      r_life    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_dmg  <= w_damage;
      r_nos  <= w_last && w_hits_next[IDX_NOS];
      r_life <= w_last && w_hits_next[IDX_LIFE];
      if (bus.frame_tick && (r_state != ST_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state <= ST_SCAN;
            r_idx   <= 3'd0;
            r_hits  <= '0;
            r_car_x <= bus.CarX;
            r_car_y <= bus.CarY;
            r_car_w <= bus.CarW;
            r_car_h <= bus.CarH;
          end
        end
        ST_SCAN: begin
          r_hits <= w_hits_next;
          r_idx  <= r_idx + 3'd1;
          if (w_last) begin
            r_state <= ST_DONE;
            r_trshd <= w_hits_next;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)                               r_invuln_tmr <= '0;
    else if (w_damage)                         r_invuln_tmr <= TMR_W'(INVULN_FRAMES);
    else if (bus.frame_tick && r_invuln_tmr != '0) r_invuln_tmr <= r_invuln_tmr - 1'b1;
  end

`ifdef COLLIDE_SHIELD_EN
  localparam int IDX_SHIELD = int'(SHIELD);
  logic [TMR_W-1:0] r_shield_tmr;

  always_ff @(posedge i_clk) begin
    if (i_reset)                                   r_shield_tmr <= '0;
    else if (w_last && w_hits_next[IDX_SHIELD])    r_shield_tmr <= TMR_W'(SHIELD_FRAMES);
    else if (bus.frame_tick && r_shield_tmr != '0) r_shield_tmr <= r_shield_tmr - 1'b1;
  end

  assign w_shield_on = (r_shield_tmr != '0);
`else
  assign w_shield_on = 1'b0;
`endif

  assign bus.trshdObjs     = r_trshd;
  assign bus.damage_pulse  = r_dmg;
  assign bus.nos_pulse     = r_nos;
  assign bus.life_pulse    = r_life;
  assign bus.shield_active = w_shield_on;
  assign bus.invuln        = (r_invuln_tmr != '0);
  assign bus.busy          = (r_state != ST_IDLE);
  assign bus.overrun       = r_overrun;

endmodule

// File: tb/tb_collision_detect.sv
// Randomized self-checking bench for collision_detect against a frame-level reference model.
module tb_collision_detect;
  import hp_pkg::*;

  localparam int M   = 2;
  localparam int INV = 60;
  localparam int SHF = 300;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  collision_detect_if bus ();

  collision_detect #(.HIT_MARGIN(M), .INVULN_FRAMES(INV), .SHIELD_FRAMES(SHF)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int inv_m   = 0;
  int sh_m    = 0;
  logic [7:0] trshd_m = '0;
  int cx, cy, cw, ch;
  int ox [8], oy [8], ow [8], oh [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_hit(input int x, input int y, input int w, input int h);
    if (w <= 2*M || h <= 2*M) return 1'b0;
    return (cx < x + w - M) && (x + M < cx + cw) && (cy < y + h - M) && (y + M < cy + ch);
  endfunction

  task automatic apply();
    bus.CarX = 11'(cx); bus.CarY = 11'(cy); bus.CarW = 11'(cw); bus.CarH = 11'(ch);
    for (int i = 0; i < 8; i++) begin
      bus.ObjX[i] = 11'(ox[i]); bus.ObjY[i] = 11'(oy[i]);
      bus.ObjW[i] = 11'(ow[i]); bus.ObjH[i] = 11'(oh[i]);
    end
  endtask

  task automatic park_all();
    for (int i = 0; i < 8; i++) begin
      ox[i] = 1800; oy[i] = 1800; ow[i] = 20; oh[i] = 20;
    end
  endtask

  task automatic tick_model();
    if (inv_m > 0) inv_m--;
    if (sh_m > 0) sh_m--;
  endtask

  // One full frame: tick, scan, check results on the DONE cycle and the cycle after
  task automatic frame(input string tag);
    logic [7:0] hits;
    bit haz, dmg;
    apply();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    tick_model();
    chk({tag, "_busy_scan"}, 32'(bus.busy), 32'd1);
    for (int i = 0; i < 8; i++) hits[i] = ref_hit(ox[i], oy[i], ow[i], oh[i]);
    haz = hits[0] | hits[1] | hits[2] | hits[5] | hits[6];
    dmg = haz && inv_m == 0 && sh_m == 0;
    if (dmg) inv_m = INV;
`ifdef COLLIDE_SHIELD_EN
    if (hits[7]) sh_m = SHF;
`endif
    trshd_m = hits;
    repeat (8) @(negedge clk);
    chk({tag, "_trshd"},  32'(bus.trshdObjs),     32'(trshd_m));
    chk({tag, "_dmg"},    32'(bus.damage_pulse),  32'(dmg));
    chk({tag, "_nos"},    32'(bus.nos_pulse),     32'(hits[3]));
    chk({tag, "_life"},   32'(bus.life_pulse),    32'(hits[4]));
    chk({tag, "_invuln"}, 32'(bus.invuln),        32'(inv_m != 0));
    chk({tag, "_shield"}, 32'(bus.shield_active), 32'(sh_m != 0));
    @(negedge clk);
    chk({tag, "_pulses_off"}, {29'd0, bus.damage_pulse, bus.nos_pulse, bus.life_pulse}, 32'd0);
    chk({tag, "_idle"},       32'(bus.busy),      32'd0);
    chk({tag, "_hold"},       32'(bus.trshdObjs), 32'(trshd_m));
    chk({tag, "_overrun"},    32'(bus.overrun),   32'd0);
  endtask

  initial begin
    reset = 1'b1;
    bus.frame_tick = 1'b0;
    cx = 100; cy = 400; cw = 32; ch = 48;
    park_all();
    apply();
    repeat (3) @(negedge clk);
    chk("rst_trshd",  32'(bus.trshdObjs), 32'd0);
    chk("rst_flags",  {24'd0, bus.damage_pulse, bus.nos_pulse, bus.life_pulse,
                       bus.shield_active, bus.invuln, bus.busy, bus.overrun, 1'b0}, 32'd0);
    reset = 1'b0;

    // Single hazard hit
    ox[0] = 110; oy[0] = 410; ow[0] = 32; oh[0] = 19;
    frame("t1");
    chk("t1_trshd_const", 32'(bus.trshdObjs), 32'h01);
    chk("t1_invuln_const", 32'(bus.invuln), 32'd1);

    // Edge touch versus overlap on X
    ox[0] = 132; frame("t2_edge");
    chk("t2_edge_const", 32'(bus.trshdObjs), 32'h00);
    ox[0] = 128; frame("t2_ovl");
    chk("t2_ovl_const", 32'(bus.trshdObjs), 32'h01);

    // NOS and life together
    park_all();
    ox[3] = 110; oy[3] = 410; ow[3] = 32; oh[3] = 19;
    ox[4] = 90;  oy[4] = 430; ow[4] = 20; oh[4] = 30;
    frame("t3");
    chk("t3_trshd_const", 32'(bus.trshdObjs), 32'h18);

    // Repeated hazard hits across the invulnerability window
    park_all();
    ox[1] = 105; oy[1] = 420; ow[1] = 10; oh[1] = 10;
    for (int f = 0; f < 66; f++) frame("t4");

    // Shield pickup followed by a hazard
    park_all();
    ox[7] = 105; oy[7] = 420; ow[7] = 10; oh[7] = 10;
    frame("t5_pick");
    park_all();
    ox[5] = 105; oy[5] = 420; ow[5] = 10; oh[5] = 10;
    frame("t5_haz");

    // Randomized frames around the car
    for (int f = 0; f < 150; f++) begin
      cx = int'($urandom_range(0, 300)); cy = int'($urandom_range(0, 300));
      cw = int'($urandom_range(0, 60));  ch = int'($urandom_range(0, 60));
      for (int i = 0; i < 8; i++) begin
        ox[i] = cx + int'($urandom_range(0, 120)) - 50;
        oy[i] = cy + int'($urandom_range(0, 120)) - 50;
        if (ox[i] < 0) ox[i] = 0;
        if (oy[i] < 0) oy[i] = 0;
        ow[i] = int'($urandom_range(0, 40));
        oh[i] = int'($urandom_range(0, 40));
        if ($urandom_range(0, 3) == 0) ox[i] = 1900;
      end
      frame("rnd");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Extra tick during a scan, then reset in the middle of the scan
    cx = 100; cy = 400; cw = 32; ch = 48;
    park_all();
    ox[0] = 110; oy[0] = 410; ow[0] = 32; oh[0] = 19;
    apply();
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b1;
    @(negedge clk) bus.frame_tick = 1'b0;
    chk("t6_overrun", 32'(bus.overrun), 32'd1);
    chk("t6_busy",    32'(bus.busy),    32'd1);
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    inv_m = 0; sh_m = 0; trshd_m = '0;
    chk("t6_rst_trshd", 32'(bus.trshdObjs), 32'd0);
    chk("t6_rst_flags", {25'd0, bus.damage_pulse, bus.nos_pulse, bus.life_pulse,
                         bus.shield_active, bus.invuln, bus.busy, bus.overrun}, 32'd0);
    repeat (10) @(negedge clk);
    chk("t6_no_result", 32'(bus.trshdObjs), 32'd0);
    frame("t6_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
